// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// md_op encoding, FSM states and op-classification helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } mdOp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mduState_e;

    function automatic logic isStartOp(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                          MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic isDivOp(input logic [3:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: computes the HI/LO result an op will commit,
// plus a divide-by-zero flag.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       mdOp,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] pendingHi,
    output logic [WIDTH-1:0] pendingLo,
    output logic             divByZero
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    acc;
    logic [W2-1:0]    sProd;
    logic [W2-1:0]    uProd;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] magQ;
    logic [WIDTH-1:0] magR;
    logic [WIDTH-1:0] sQuot;
    logic [WIDTH-1:0] sRem;
    logic             rtZero;

    always_comb begin
        acc    = {hi, lo};
        sProd  = $signed({{WIDTH{rsData[WIDTH-1]}}, rsData})
               * $signed({{WIDTH{rtData[WIDTH-1]}}, rtData});
        uProd  = {{WIDTH{1'b0}}, rsData} * {{WIDTH{1'b0}}, rtData};

        // Substitute 1 for a zero divisor so the divider never sees /0;
        // its result is discarded in that case anyway.
        rtZero  = (rtData == '0);
        divisor = rtZero ? WIDTH'(1) : rtData;

        // Signed divide on magnitudes; most-negative / -1 falls out naturally.
        absA  = rsData[WIDTH-1]  ? -rsData  : rsData;
        absB  = divisor[WIDTH-1] ? -divisor : divisor;
        magQ  = absA / absB;
        magR  = absA % absB;
        sQuot = (rsData[WIDTH-1] ^ divisor[WIDTH-1]) ? -magQ : magQ;
        sRem  = rsData[WIDTH-1] ? -magR : magR;

        divByZero = isDivOp(mdOp) && rtZero;
        {pendingHi, pendingLo} = acc;

        case (mdOp)
            MD_MULT:  {pendingHi, pendingLo} = sProd;
            MD_MULTU: {pendingHi, pendingLo} = uProd;
            MD_MADD:  {pendingHi, pendingLo} = acc + sProd;
            MD_MADDU: {pendingHi, pendingLo} = acc + uProd;
            MD_MSUB:  {pendingHi, pendingLo} = acc - sProd;
            MD_MSUBU: {pendingHi, pendingLo} = acc - uProd;
            MD_DIV: begin
                if (!rtZero) {pendingHi, pendingLo} = {sRem, sQuot};
            end
            MD_DIVU: begin
                if (!rtZero) {pendingHi, pendingLo} = {rsData % divisor, rsData / divisor};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO, configurable latency,
// flush-abort and a registered busy flag for the hazard unit.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       md_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    mduState_e        state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] pendingHi;
    logic [WIDTH-1:0] pendingLo;
    logic             pendingDivZero;

    logic [WIDTH-1:0] calcHi;
    logic [WIDTH-1:0] calcLo;
    logic             calcDivZero;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) uCalc (
        .mdOp      (md_op),
        .rsData    (rs_data),
        .rtData    (rt_data),
        .hi        (hi),
        .lo        (lo),
        .pendingHi (calcHi),
        .pendingLo (calcLo),
        .divByZero (calcDivZero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            counter        <= '0;
            hi             <= '0;
            lo             <= '0;
            pendingHi      <= '0;
            pendingLo      <= '0;
            pendingDivZero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush) begin
                        if (isStartOp(md_op)) begin
                            pendingHi      <= calcHi;
                            pendingLo      <= calcLo;
                            pendingDivZero <= calcDivZero;
                            counter        <= isDivOp(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                                             : CNT_W'(MULT_CYCLES - 1);
                            busy           <= 1'b1;
                            state          <= ST_BUSY;
                        end else if (md_op == MD_MTHI) begin
                            hi <= rs_data;
                        end else if (md_op == MD_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ops presented while busy (including on the final edge) are dropped.
                    if (flush) begin
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (counter == '0) begin
                        if (!pendingDivZero) begin
                            hi <= pendingHi;
                            lo <= pendingLo;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (md_op == MD_MFHI)      rd_data = hi;
        else if (md_op == MD_MFLO) rd_data = lo;
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table of full ops plus
// hand-written flush, busy-ignore, divide-by-zero and async-reset sequences.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic [3:0]   md_op;
    logic         flush;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd_data;

    int nCompared   = 0;
    int nMismatched = 0;

    mdu_seq #(
        .WIDTH       (W),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mdOp_e        op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        int           expBusy;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an op for one cycle, then count busy cycles (bounded).
    task automatic issue(input mdOp_e op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         output int nBusy);
        @(negedge clk);
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
        @(negedge clk);
        md_op = MD_NONE;
        nBusy = 0;
        while (busy === 1'b1 && nBusy < 100) begin
            nBusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nBusy;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIVU,  32'h7,        32'h2,        10, 32'h1,        32'h3};
        vecs[4]  = '{MD_MTHI,  32'h1,        32'h0,        0,  32'h1,        32'h3};
        vecs[5]  = '{MD_MTLO,  32'h0,        32'h0,        0,  32'h1,        32'h0};
        vecs[6]  = '{MD_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h1,        32'h1};
        vecs[7]  = '{MD_MTHI,  32'h0,        32'h0,        0,  32'h0,        32'h1};
        vecs[8]  = '{MD_MSUBU, 32'h2,        32'h1,        5,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9]  = '{MD_MSUB,  32'h3,        32'h4,        5,  32'hFFFFFFFF, 32'hFFFFFFF3};
        vecs[10] = '{MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFD, 32'hFFFFFFF4};
        vecs[11] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000};
        vecs[12] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h3};

        reset   = 1'b0;
        md_op   = MD_NONE;
        flush   = 1'b0;
        rs_data = '0;
        rt_data = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, nBusy);
            check($sformatf("vec%0d_busycycles", i), W'(nBusy), W'(vecs[i].expBusy));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
        end

        // mfhi/mflo/none read path
        md_op = MD_MFHI; #1 check("rd_mfhi", rd_data, 32'hFFFFFFFF);
        md_op = MD_MFLO; #1 check("rd_mflo", rd_data, 32'h3);
        md_op = MD_NONE; #1 check("rd_none", rd_data, 32'h0);

        // divide by zero; mtlo held through busy (incl. final edge) is ignored
        issue(MD_MTHI, 32'hAA, 32'h0, nBusy);
        issue(MD_MTLO, 32'hBB, 32'h0, nBusy);
        @(negedge clk);
        md_op   = MD_DIVU;
        rs_data = 32'h5;
        rt_data = 32'h0;
        @(negedge clk);
        md_op   = MD_MTLO;
        rs_data = 32'h55;
        nBusy   = 0;
        while (busy === 1'b1 && nBusy < 100) begin
            nBusy++;
            @(negedge clk);
        end
        md_op = MD_NONE;
        check("div0_busycycles", W'(nBusy), W'(10));
        check("div0_hi", hi, 32'hAA);
        check("div0_lo", lo, 32'hBB);

        // flush in cycle 3 of a mult
        @(negedge clk);
        md_op   = MD_MULT;
        rs_data = 32'h3;
        rt_data = 32'h4;
        @(negedge clk);
        md_op = MD_NONE;
        check("flush_busy_c1", W'(busy), W'(1));
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", W'(busy), W'(0));
        md_op = MD_MFHI; #1 check("flush_rd_hi", rd_data, 32'hAA);
        md_op = MD_NONE;
        repeat (6) @(negedge clk);
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'hBB);

        // flush in IDLE discards the op of that cycle
        flush   = 1'b1;
        md_op   = MD_MTHI;
        rs_data = 32'h99;
        @(negedge clk);
        flush = 1'b0;
        md_op = MD_NONE;
        check("idleflush_hi", hi, 32'hAA);
        check("idleflush_busy", W'(busy), W'(0));

        // async reset mid-divide
        @(negedge clk);
        md_op   = MD_DIV;
        rs_data = 32'd100;
        rt_data = 32'd7;
        @(negedge clk);
        md_op = MD_NONE;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_hi", hi, '0);
        check("arst_lo", lo, '0);
        @(negedge clk);
        reset = 1'b1;
        issue(MD_MULT, 32'd3, 32'd4, nBusy);
        check("post_rst_busycycles", W'(nBusy), W'(5));
        check("post_rst_hi", hi, 32'h0);
        check("post_rst_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit holding HI/LO, for the pipelined successor of the single-cycle core.
- Sits beside the ALU in the execute stage and is driven by the control unit's md_op field.
- Adds configurable latency, multiply-accumulate (madd/msub), flush-abort and a busy handshake that the hazard unit uses to stall.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- md_op  in  4  operation code; encoding in shared package.
- flush  in  1  abort the in-flight op; suppress any op presented this cycle.
- rs_data  in  WIDTH  operand A / mthi-mtlo source.
- rt_data  in  WIDTH  operand B.
- busy  out  1  op in flight (registered).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  mfhi → hi, mflo → lo, otherwise 0 (combinational).

Behaviour:
- Reset (async, reset=0): hi=0, lo=0, busy=0, state=IDLE, counter=0, pending result cleared. Reset mid-operation abandons the op; HI/LO read 0 afterwards.
- States: IDLE, BUSY.
- IDLE, no flush, md_op a start op (MULT..MSUBU) at edge T:
  - Latch the computed result (pending_hi, pending_lo); load counter with LAT-1, where LAT is MULT_CYCLES or DIV_CYCLES.
  - Go BUSY; busy=1 during cycles T+1 .. T+LAT.
- BUSY: counter decrements each edge. At the edge where counter==0: commit pending to hi/lo, busy←0, go IDLE. New hi/lo is visible from cycle T+LAT+1.
- Arithmetic:
  - mult: signed 2·WIDTH product; {hi,lo}=product.
  - multu: unsigned 2·WIDTH product; {hi,lo}=product.
  - madd/maddu: {hi,lo}+=product, where {hi,lo} is sampled at start; wrap modulo 2^(2·WIDTH).
  - msub/msubu: {hi,lo}−=product, same sampling and wrap rule.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Overflow case (div of most-negative by −1): lo=most-negative, hi=0.
- Divide by zero (rt_data==0): busy still runs DIV_CYCLES; hi/lo unchanged at commit.
- mthi/mtlo in IDLE: hi or lo ← rs_data at that edge; the other register is untouched.
- mfhi/mflo: pure read via rd_data; no state change. Returns the current hi/lo, including while BUSY (the hazard unit stalls these).
- Any op other than NONE presented while BUSY is ignored. The hazard unit must stall; the block does not queue.
- flush=1: in BUSY, return to IDLE next edge, busy←0, hi/lo unchanged. In IDLE, the md_op of that cycle is discarded.
- Ops present on the edge busy deasserts are ignored; they are accepted from the next cycle.
- Undefined md_op codes are treated as NONE.

Decomposition:
- Shared package mdu_pkg: md_op encoding constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12), state encoding, and a helper deciding "is start op".
- One natural sub-module, mdu_calc: combinational, produces {pending_hi, pending_lo} plus a div-by-zero flag from md_op, rs_data, rt_data, hi and lo.
- mdu_seq keeps the FSM, counter and registers.

Test Plan:
- mult rs=0xFFFFFFFF, rt=2 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as multu → hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=2 → lo=3, hi=1.
- mthi 0x1, mtlo 0x0, then madd rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0x1, lo=0x1. msubu rs=2, rt=1 from hi=0, lo=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- Seed hi=0xAA, lo=0xBB, then divu by 0 → busy 10 cycles; hi=0xAA, lo=0xBB. Also: mtlo issued during busy is ignored.
- mult started, flush asserted in cycle 3 of busy → busy=0 next cycle; hi/lo keep the pre-op values; mfhi rd_data equals the old hi.
- div started, reset driven low mid-busy asynchronously → busy, hi and lo go 0 immediately, without waiting for a clock edge; after release, mult 3×4 → lo=12, hi=0.
